// File: rtl/snd_pkg.sv
// Shared sound definitions: sound codes, sequencer state encoding, pending-bit
// layout and grant priority ranking. Used by the sequencer and the motion logic.
package snd_pkg;

  typedef enum logic [1:0] {
    SND_STOP = 2'b00,
    SND_PONG = 2'b01,
    SND_PING = 2'b10,
    SND_GO   = 2'b11
  } snd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } snd_state_e;

  // Bit positions inside the pending vector {go, pong, ping}
  localparam int PEND_PING = 0;
  localparam int PEND_PONG = 1;
  localparam int PEND_GO   = 2;

  localparam int CNT_W = 8;

  // Grant priority of a code: go > pong > ping > stop (codes are not ordered)
  function automatic logic [1:0] snd_rank(input snd_code_e c);
    case (c)
      SND_GO:   return 2'd3;
      SND_PONG: return 2'd2;
      SND_PING: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Frame tick detector: pulses while the pixel scan is on the last visible
// pixel of the frame. Shared by the sound sequencer and the motion logic.
module frame_tick #(
  parameter int VISIBLECOLS = 640,
  parameter int VISIBLEROWS = 480
) (
  input  logic [9:0] x_pix,
  input  logic [9:0] y_pix,
  output logic       tick
);

  assign tick = (x_pix == 10'(VISIBLECOLS - 1)) && (y_pix == 10'(VISIBLEROWS - 1));

endmodule

// File: rtl/sound_sequencer.sv
// Sound sequencer: latches go/pong/ping requests as pending bits, grants them
// by fixed priority and plays each for a number of frames followed by a gap.
// Optional macro SOUND_PREEMPT_EN lets a higher-priority pending request
// interrupt a sound that is playing or in its gap.
module sound_sequencer
  import snd_pkg::*;
#(
  parameter int VISIBLECOLS = 640,
  parameter int VISIBLEROWS = 480,
  parameter int DUR_GO      = 30,
  parameter int DUR_PONG    = 4,
  parameter int DUR_PING    = 4,
  parameter int GAP_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] x_pix,
  input  logic [9:0] y_pix,
  input  logic       req_go,
  input  logic       req_pong,
  input  logic       req_ping,
  output logic       mute,
  output logic [1:0] code_sound,
  output logic       busy
);

  // Counters hold "remaining ticks minus one", so the loaded value is DUR-1
  localparam logic [CNT_W-1:0] LD_GO   = CNT_W'(DUR_GO - 1);
  localparam logic [CNT_W-1:0] LD_PONG = CNT_W'(DUR_PONG - 1);
  localparam logic [CNT_W-1:0] LD_PING = CNT_W'(DUR_PING - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = (GAP_FRAMES > 0) ? CNT_W'(GAP_FRAMES - 1) : '0;

  snd_state_e       state_q, state_d;
  snd_code_e        code_q, code_d;
  logic             mute_q, mute_d;
  logic [2:0]       pend_q, pend_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  logic             tick;
  logic             gnt_any;
  logic             grant;
  logic             preempt;
  snd_code_e        gnt_code;
  logic [2:0]       gnt_mask;
  logic [CNT_W-1:0] gnt_dur;

  frame_tick #(
    .VISIBLECOLS(VISIBLECOLS),
    .VISIBLEROWS(VISIBLEROWS)
  ) u_frame_tick (
    .x_pix(x_pix),
    .y_pix(y_pix),
    .tick (tick)
  );

  assign gnt_any = |pend_q;

  // Fixed-priority encoder over the registered pending bits
  always_comb begin
    gnt_code = SND_STOP;
    gnt_mask = 3'b000;
    gnt_dur  = '0;
    if (pend_q[PEND_GO]) begin
      gnt_code = SND_GO;
      gnt_mask = 3'b001 << PEND_GO;
      gnt_dur  = LD_GO;
    end else if (pend_q[PEND_PONG]) begin
      gnt_code = SND_PONG;
      gnt_mask = 3'b001 << PEND_PONG;
      gnt_dur  = LD_PONG;
    end else if (pend_q[PEND_PING]) begin
      gnt_code = SND_PING;
      gnt_mask = 3'b001 << PEND_PING;
      gnt_dur  = LD_PING;
    end
  end

`ifdef SOUND_PREEMPT_EN
  // In GAP the current code is stop, so any pending request outranks it
  assign preempt = gnt_any && (snd_rank(gnt_code) > snd_rank(code_q));
`else
  assign preempt = 1'b0;
`endif

  // Next-state, output and counter logic of the play/gap sequencer
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    mute_d  = mute_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant = gnt_any;
      end
      ST_PLAY: begin
        if (preempt) begin
          grant = 1'b1;
        end else if (tick) begin
          if (dur_q == '0) begin
            mute_d = 1'b1;
            code_d = SND_STOP;
            if (GAP_FRAMES > 0) begin
              state_d = ST_GAP;
              gap_d   = LD_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (preempt) begin
          grant = 1'b1;
        end else if (tick) begin
          if (gap_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A grant loads the duration as-is even on a tick: counting starts next tick
    if (grant) begin
      state_d = ST_PLAY;
      code_d  = gnt_code;
      mute_d  = 1'b0;
      dur_d   = gnt_dur;
    end
    // A same-type request in the grant cycle re-arms the bit (queued repeat)
    pend_d = (pend_q & ~(grant ? gnt_mask : 3'b000)) | {req_go, req_pong, req_ping};
  end

  // State, output and counter registers; clr wins over requests and ticks
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      code_q  <= SND_STOP;
      mute_q  <= 1'b1;
      pend_q  <= 3'b000;
      dur_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      mute_q  <= mute_d;
      pend_q  <= pend_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
    end
  end

  assign mute       = mute_q;
  assign code_sound = code_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Testbench for sound_sequencer: table-driven vectors with explicit ticks,
// then scenario sequences checked against a behavioural model via a scoreboard.
module tb_sound_sequencer;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DGO   = 30;
  localparam int DPONG = 4;
  localparam int DPING = 4;
  localparam int GAPF  = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [9:0] x_pix = '0;
  logic [9:0] y_pix = '0;
  logic       req_go = 1'b0, req_pong = 1'b0, req_ping = 1'b0;
  logic       mute;
  logic [1:0] code_sound;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       mute;
    logic [1:0] code;
    logic       busy;
  } exp_t;

  typedef struct {
    logic c, g, pg, pi, tk;
    exp_t e;
  } vec_t;

  typedef struct {
    logic [1:0] code;
    int         ticks;
  } seg_t;

  exp_t sb_q[$];
  seg_t segs[$];
  vec_t tab[26];

  // Behavioural model: remaining-tick counters, pending bits {go,pong,ping}
  int         m_state = 0;
  logic [2:0] m_pend = 3'b000;
  int         m_left = 0;
  int         m_gap = 0;
  logic [1:0] m_code = 2'b00;
  logic       m_mute = 1'b1;

  int   frame_ph = 0;
  logic last_busy = 1'b0;
  logic [1:0] last_code = 2'b00;

  always #5 clk = ~clk;

  sound_sequencer #(
    .VISIBLECOLS(COLS),
    .VISIBLEROWS(ROWS),
    .DUR_GO     (DGO),
    .DUR_PONG   (DPONG),
    .DUR_PING   (DPING),
    .GAP_FRAMES (GAPF)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .x_pix     (x_pix),
    .y_pix     (y_pix),
    .req_go    (req_go),
    .req_pong  (req_pong),
    .req_ping  (req_ping),
    .mute      (mute),
    .code_sound(code_sound),
    .busy      (busy)
  );

  function automatic int rank_of(input logic [1:0] c);
    case (c)
      2'b11:   return 3;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic c, g, pg, pi, tk, output exp_t e);
    logic [2:0] req;
    logic [2:0] gb;
    int         best_r;
    logic       do_g;
    req = {g, pg, pi};
    if (c) begin
      m_state = 0; m_pend = 3'b000; m_left = 0; m_gap = 0;
      m_code = 2'b00; m_mute = 1'b1;
    end else begin
      gb = m_pend[2] ? 3'b100 : m_pend[1] ? 3'b010 : m_pend[0] ? 3'b001 : 3'b000;
      best_r = gb[2] ? 3 : gb[1] ? 2 : gb[0] ? 1 : 0;
      do_g = 1'b0;
      if (m_state == 0) do_g = (gb != 3'b000);
`ifdef SOUND_PREEMPT_EN
      else if (best_r > rank_of(m_code)) do_g = 1'b1;
`endif
      if (do_g) begin
        m_state = 1;
        m_mute  = 1'b0;
        m_code  = gb[2] ? 2'b11 : gb[1] ? 2'b01 : 2'b10;
        m_left  = gb[2] ? DGO : gb[1] ? DPONG : DPING;
        m_pend  = (m_pend & ~gb) | req;
      end else begin
        m_pend = m_pend | req;
        if (tk && m_state == 1) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mute = 1'b1;
            m_code = 2'b00;
            if (GAPF > 0) begin m_state = 2; m_gap = GAPF; end
            else m_state = 0;
          end
        end else if (tk && m_state == 2) begin
          m_gap = m_gap - 1;
          if (m_gap == 0) m_state = 0;
        end
      end
    end
    e.mute = m_mute;
    e.code = m_code;
    e.busy = (m_state != 0);
  endtask

  // One clock cycle: drive inputs, push expectation, sample after the edge
  task automatic cyc(input logic c, g, pg, pi, tk, input bit use_tab,
                     input exp_t tab_e, input string tag);
    exp_t me, e;
    clr = c; req_go = g; req_pong = pg; req_ping = pi;
    if (tk) begin
      x_pix = 10'(COLS - 1); y_pix = 10'(ROWS - 1);
    end else if ($urandom_range(0, 1) == 1) begin
      x_pix = 10'(COLS - 1); y_pix = 10'd0;
    end else begin
      x_pix = 10'($urandom_range(0, COLS - 2)); y_pix = 10'(ROWS - 1);
    end
    model_step(c, g, pg, pi, tk, me);
    sb_q.push_back(use_tab ? tab_e : me);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(tag, int'({mute, code_sound, busy}), int'({e.mute, e.code, e.busy}));
  endtask

  // Scenario cycle: free-running tick every 8 cycles, segment logging
  task automatic step(input logic c, g, pg, pi);
    logic tk;
    int   idx;
    exp_t dummy;
    dummy = '{1'b0, 2'b00, 1'b0};
    tk = (frame_ph == 7);
    frame_ph = (frame_ph + 1) % 8;
    if (busy === 1'b1) begin
      if (segs.size() == 0 || !last_busy || code_sound != last_code)
        segs.push_back('{code_sound, 0});
      if (tk) begin
        idx = segs.size() - 1;
        segs[idx].ticks = segs[idx].ticks + 1;
      end
    end
    last_busy = (busy === 1'b1);
    last_code = code_sound;
    cyc(c, g, pg, pi, tk, 1'b0, dummy, "scoreboard");
  endtask

  task automatic run_until_idle(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (!(busy === 1'b0 && m_state == 0 && m_pend == 3'b000) && n < max_cyc) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required idle", nm, busy, n);
    end
  endtask

  task automatic chk_seg(input string nm, input int idx, input logic [1:0] code, input int ticks);
    checks++;
    if (idx >= segs.size()) begin
      errors++;
      $display("FAIL %s: segment %0d missing, required code %0d for %0d ticks", nm, idx, code, ticks);
    end else if (segs[idx].code != code || segs[idx].ticks != ticks) begin
      errors++;
      $display("FAIL %s: segment %0d got code %0d ticks %0d, required code %0d ticks %0d",
               nm, idx, segs[idx].code, segs[idx].ticks, code, ticks);
    end
  endtask

  task automatic set_vec(input int i, input logic c, g, pg, pi, tk,
                         input logic m, input logic [1:0] cd, input logic b);
    tab[i].c = c; tab[i].g = g; tab[i].pg = pg; tab[i].pi = pi; tab[i].tk = tk;
    tab[i].e = '{m, cd, b};
  endtask

  initial begin
    int n;
    //           c  g  pg pi tk   mute code   busy
    set_vec( 0, 1, 0, 0, 0, 0,   1, 2'b00, 0);
    set_vec( 1, 1, 0, 0, 1, 0,   1, 2'b00, 0);
    set_vec( 2, 0, 0, 0, 0, 0,   1, 2'b00, 0);
    set_vec( 3, 0, 0, 0, 1, 0,   1, 2'b00, 0);
    set_vec( 4, 0, 0, 0, 0, 0,   0, 2'b10, 1);
    set_vec( 5, 0, 0, 0, 0, 1,   0, 2'b10, 1);
    set_vec( 6, 0, 0, 0, 0, 1,   0, 2'b10, 1);
    set_vec( 7, 0, 0, 0, 0, 1,   0, 2'b10, 1);
    set_vec( 8, 0, 0, 0, 0, 0,   0, 2'b10, 1);
    set_vec( 9, 0, 0, 0, 0, 1,   1, 2'b00, 1);
    set_vec(10, 0, 0, 0, 0, 1,   1, 2'b00, 1);
    set_vec(11, 0, 0, 0, 0, 1,   1, 2'b00, 0);
    set_vec(12, 0, 0, 1, 0, 0,   1, 2'b00, 0);
    set_vec(13, 0, 0, 0, 0, 1,   0, 2'b01, 1);
    set_vec(14, 0, 0, 0, 0, 1,   0, 2'b01, 1);
    set_vec(15, 0, 0, 0, 0, 1,   0, 2'b01, 1);
    set_vec(16, 0, 0, 0, 0, 1,   0, 2'b01, 1);
    set_vec(17, 0, 0, 0, 0, 1,   1, 2'b00, 1);
    set_vec(18, 0, 0, 0, 0, 1,   1, 2'b00, 1);
    set_vec(19, 0, 0, 0, 0, 1,   1, 2'b00, 0);
    set_vec(20, 0, 1, 0, 0, 0,   1, 2'b00, 0);
    set_vec(21, 0, 0, 0, 0, 0,   0, 2'b11, 1);
    set_vec(22, 0, 0, 1, 0, 1,   0, 2'b11, 1);
    set_vec(23, 1, 0, 0, 0, 1,   1, 2'b00, 0);
    set_vec(24, 0, 0, 0, 0, 0,   1, 2'b00, 0);
    set_vec(25, 0, 0, 0, 0, 0,   1, 2'b00, 0);

    for (int i = 0; i < 26; i++)
      cyc(tab[i].c, tab[i].g, tab[i].pg, tab[i].pi, tab[i].tk, 1'b1, tab[i].e,
          $sformatf("vec%0d", i));

    // Reset held for two cycles
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_state", int'({mute, code_sound, busy}), 4'b1000);

    // Single ping requested in cycle 10, audible in cycle 12
    segs.delete();
    frame_ph = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("ping_cycle11_mute", int'(mute), 1);
    step(0, 0, 0, 0);
    chk("ping_cycle12", int'({mute, code_sound}), 3'b010);
    run_until_idle(200, "ping");
    chk_seg("ping_play", 0, 2'b10, DPING);
    chk_seg("ping_gap", 1, 2'b00, GAPF);
    chk("ping_nsegs", segs.size(), 2);

    // Simultaneous requests served go, pong, ping with gaps between
    segs.delete();
    step(0, 1, 1, 1);
    run_until_idle(1000, "simul");
    chk_seg("simul_go", 0, 2'b11, DGO);
    chk_seg("simul_gap0", 1, 2'b00, GAPF);
    chk_seg("simul_pong", 2, 2'b01, DPONG);
    chk_seg("simul_gap1", 3, 2'b00, GAPF);
    chk_seg("simul_ping", 4, 2'b10, DPING);
    chk_seg("simul_gap2", 5, 2'b00, GAPF);

    // Pong held across its own grant cycle plays twice
    segs.delete();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    run_until_idle(300, "repeat");
    chk_seg("repeat_pong0", 0, 2'b01, DPONG);
    chk_seg("repeat_gap0", 1, 2'b00, GAPF);
    chk_seg("repeat_pong1", 2, 2'b01, DPONG);
    chk_seg("repeat_gap1", 3, 2'b00, GAPF);
    chk("repeat_nsegs", segs.size(), 4);

    // Go requested while ping is playing
    segs.delete();
    step(0, 0, 0, 1);
    n = 0;
    while (code_sound !== 2'b10 && n < 10) begin step(0, 0, 0, 0); n++; end
    chk("preempt_ping_started", int'(code_sound), 2'b10);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
`ifdef SOUND_PREEMPT_EN
    chk("preempt_go_now", int'(code_sound), 2'b11);
    run_until_idle(600, "preempt");
    chk_seg("preempt_go", 1, 2'b11, DGO);
`else
    chk("nopreempt_ping_kept", int'(code_sound), 2'b10);
    run_until_idle(600, "preempt");
    chk_seg("nopreempt_ping", 0, 2'b10, DPING);
    chk_seg("nopreempt_gap", 1, 2'b00, GAPF);
    chk_seg("nopreempt_go", 2, 2'b11, DGO);
`endif

    // Reset on the second tick of go, with a ping pending behind it
    segs.delete();
    step(0, 1, 0, 0);
    n = 0;
    while (code_sound !== 2'b11 && n < 10) begin step(0, 0, 0, 0); n++; end
    step(0, 0, 0, 1);
    n = 0;
    begin
      int nt;
      nt = 0;
      while (n < 100) begin
        if (frame_ph == 7 && nt == 1) begin
          step(1, 0, 0, 0);
          break;
        end
        if (frame_ph == 7) nt++;
        step(0, 0, 0, 0);
        n++;
      end
    end
    chk("midplay_clr", int'({mute, code_sound, busy}), 4'b1000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("midplay_pend_cleared", int'({mute, code_sound, busy}), 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter VISIBLECOLS, default 640, which is the visible columns per line.
REQ-002 SHALL have parameter VISIBLEROWS, default 480, which is the visible rows per frame.
REQ-003 SHALL have parameters DUR_GO, DUR_PONG and DUR_PING, defaults 30, 4 and 4, which are each sound's length in frames (legal range 1..255).
REQ-004 SHALL have parameter GAP_FRAMES, default 2, which is the number of silent frames between sounds (legal range 0..255).
REQ-005 SHALL have port clk, input, 1 bit, the system clock.
REQ-006 SHALL have port clr, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have ports x_pix and y_pix, inputs, 10 bits each, the current pixel position.
REQ-008 SHALL have ports req_go, req_pong and req_ping, inputs, 1 bit each, which are one-cycle or level sound requests.
REQ-009 SHALL have port mute, output, 1 bit, where 1 means silence.
REQ-010 SHALL have port code_sound, output, 2 bits, encoded stop=00, pong=01, ping=10, go=11.
REQ-011 SHALL have port busy, output, 1 bit, which is 1 while the state is not IDLE.

Function
REQ-012 SHALL derive the frame tick as a single-cycle pulse when x_pix==VISIBLECOLS-1 and y_pix==VISIBLEROWS-1.
REQ-013 SHALL set a per-type pending bit on any clk edge where its request input is 1, and hold the bit until that type is granted.
REQ-014 SHALL grant by fixed priority go > pong > ping when selecting among pending bits.
REQ-015 SHALL implement the FSM states IDLE, PLAY and GAP.
REQ-016 SHALL, in IDLE with any pending bit set, move to PLAY on the next edge; on that same edge it SHALL set code_sound to the granted code, set mute=0, load dur_cnt=DUR_x-1, and clear the granted pending bit.
REQ-017 SHALL register the grant: outputs change 1 cycle after the pending bit is first visible; a request in cycle N gives outputs in cycle N+2 (pending set at edge N, grant at edge N+1).
REQ-018 SHALL, in PLAY, decrement dur_cnt on each frame tick; on a tick with dur_cnt==0 it SHALL set mute=1 and code_sound=stop, then enter GAP (loading gap_cnt=GAP_FRAMES-1) if GAP_FRAMES>0, else enter IDLE.
REQ-019 SHALL, in GAP, decrement gap_cnt on each tick; on a tick with gap_cnt==0 it SHALL enter IDLE.
REQ-020 SHALL keep the pending bit set when a request for the same type as the current grant is asserted in the grant cycle; that request is queued, not merged.
REQ-021 SHALL keep a request pending while in PLAY or GAP (no preemption unless SOUND_PREEMPT_EN), and serve it from IDLE afterwards.
REQ-022 SHALL make counters 8 bits wide with no wrap-around; a counter never decrements below 0.
REQ-023 SHALL, when a frame tick coincides with entering PLAY, leave dur_cnt at its loaded value; counting starts on the next tick, so a sound lasts DUR_x full ticks.
REQ-024 SHALL make busy combinational from the state register.

Reset
REQ-025 SHALL, on clr=1 at a clk edge, set state=IDLE, mute=1, code_sound=00, clear all pending bits, and set dur_cnt=gap_cnt=0.
REQ-026 SHALL give clr priority over all requests and ticks in the same cycle; clr during PLAY silences the output on the following cycle.
REQ-027 SHALL ignore requests asserted in the same cycle as clr.

Configuration
REQ-028 SHALL support the macro SOUND_PREEMPT_EN; when it is defined, a pending request of strictly higher priority than the current code, seen in PLAY or GAP, regrants immediately (REQ-016 timing) and the preempted sound is discarded.
REQ-029 SHALL, without SOUND_PREEMPT_EN, never interrupt a sound in PLAY before its duration expires.

Structure
REQ-030 SHALL place the sound code constants (stop, pong, ping, go) and the state encoding in the shared package snd_pkg, which the dynamic block also uses.
REQ-031 SHALL implement the frame-tick detector as the sub-module frame_tick (x_pix, y_pix → tick) so it can be reused by the motion logic.
REQ-032 SHALL keep the FSM, pending register, priority encoder and counters in sound_sequencer.

Verification
REQ-033 SHALL cover reset: assert clr for 2 cycles → mute=1, code_sound=00, busy=0.
REQ-034 SHALL cover a single ping: req_ping pulse at cycle 10 → cycle 12 code_sound=10, mute=0; after 4 ticks mute=1; busy=0 after 2 further ticks.
REQ-035 SHALL cover simultaneous requests: req_go, req_pong and req_ping in the same cycle → go plays for 30 ticks, then gap, then pong, then gap, then ping.
REQ-036 SHALL cover a queued repeat: req_pong held 3 cycles spanning the grant → pong plays twice, separated by a 2-frame gap.
REQ-037 SHALL cover preemption: with SOUND_PREEMPT_EN, req_go during ping PLAY → code_sound=11 two cycles later; without the macro, go starts only after the ping and gap complete.
REQ-038 SHALL cover reset mid-play: clr at tick 2 of go → next cycle mute=1, code_sound=00, and all pending bits are cleared.
